sha256_core_param: RTL and testbench



---
 rtl/sha256_pkg.sv | 57 +++++
 rtl/sha256_core_param_if.sv | 10 +
 rtl/sha256_round.sv | 17 +
 rtl/sha256_core_param.sv | 165 ++++++++++++++++
 tb/tb_sha256_core_param.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM states
// and the bitwise helper functions used by the compression datapath.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_FINAL
    } state_t;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_of(input logic [5:0] idx);
        return K[idx];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_core_param_if.sv
// Shared message-word bus: the core requests word addr with rq, the bus answers with data/rdy.
interface sha256_core_param_if;
    logic        rq;
    logic [3:0]  addr;
    logic        rdy;
    logic [31:0] data;

    modport master (output rq, addr, input rdy, data);
    modport slave  (input rq, addr, output rdy, data);
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h} in, {a..h} out, given K[t] and W[t].
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] st_out
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;
    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);
    assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_core_param.sv
// SHA-256 compression core with UNROLL rounds per cycle and digest chaining.
// Optional SHA256_NONCE_INJECT_EN: word NONCE_WORD comes from the nonce port instead of the bus.
//
// state     | meaning
// S_IDLE    | waiting for start; done low
// S_LOAD    | fetching W[0..15] over the word bus
// S_COMPUTE | UNROLL rounds per cycle, 64/UNROLL cycles
// S_FINAL   | add working vars into H, pulse done
module sha256_core_param
    import sha256_pkg::*;
#(
    parameter int UNROLL     = 4,
    parameter int NONCE_WORD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 abort,
`ifdef SHA256_NONCE_INJECT_EN
    input  logic [31:0]          nonce,
`endif
    input  logic [255:0]         state_in,
    output logic [255:0]         state_out,
    output logic                 busy,
    output logic                 done,
    sha256_core_param_if.master  bus
);
    localparam int NCYC = 64 / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("sha256_core_param: UNROLL must be 1, 2, 4, 8 or 16");
    end
    if (NONCE_WORD < 0 || NONCE_WORD > 15) begin : g_bad_nonce_word
        $error("sha256_core_param: NONCE_WORD must be 0..15");
    end

    state_t        state;
    logic          rq;
    logic [5:0]    cnt;
    logic [255:0]  h_reg;
    logic [255:0]  work;
    logic [31:0]   w [0:15];

    logic [6:0]                 t;
    logic [31:0]                ext [0:15+UNROLL];
    logic [UNROLL-1:0][31:0]    wr;
    logic [UNROLL-1:0][31:0]    kr;
    logic [UNROLL:0][255:0]     chain;

    logic        take;
    logic        rq_next;
    logic [31:0] word_in;

`ifdef SHA256_NONCE_INJECT_EN
    localparam logic FIRST_RQ = (NONCE_WORD != 0);
    logic inj;
    assign inj     = (cnt[3:0] == 4'(NONCE_WORD));
    assign take    = inj || (rq && bus.rdy);
    assign word_in = inj ? nonce : bus.data;
    assign rq_next = (cnt[3:0] + 4'd1) != 4'(NONCE_WORD);
`else
    localparam logic FIRST_RQ = 1'b1;
    assign take    = rq && bus.rdy;
    assign word_in = bus.data;
    assign rq_next = 1'b1;
`endif

    assign bus.rq    = rq;
    assign bus.addr  = cnt[3:0];
    assign state_out = h_reg;

    // ext[0..15] mirrors the window; ext[16..] are the next UNROLL schedule words,
    // chained so a word produced this cycle can feed j-2 of a later one.
    always_comb begin
        t = 7'({1'b0, cnt} * UNROLL);
        for (int k = 0; k < 16; k++) ext[k] = w[k];
        for (int k = 16; k < 16 + UNROLL; k++)
            ext[k] = ssig1(ext[k-2]) + ext[k-7] + ssig0(ext[k-15]) + ext[k-16];
        for (int i = 0; i < UNROLL; i++) begin
            wr[i] = (t < 7'd16) ? w[t[3:0] + 4'(i)] : ext[16+i];
            kr[i] = k_of(t[5:0] + 6'(i));
        end
    end

    assign chain[0] = work;
    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        sha256_round u_rnd (
            .st_in  (chain[i]),
            .k      (kr[i]),
            .w      (wr[i]),
            .st_out (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rq    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            h_reg <= '0;
            work  <= '0;
            for (int k = 0; k < 16; k++) w[k] <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                rq    <= 1'b0;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (cont) begin
                                work <= h_reg;
                            end else begin
                                h_reg <= state_in;
                                work  <= state_in;
                            end
                            cnt   <= '0;
                            rq    <= FIRST_RQ;
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (take) begin
                            w[cnt[3:0]] <= word_in;
                            if (cnt[3:0] == 4'd15) begin
                                rq    <= 1'b0;
                                cnt   <= '0;
                                state <= S_COMPUTE;
                            end else begin
                                cnt <= cnt + 6'd1;
                                rq  <= rq_next;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        work <= chain[UNROLL];
                        if (t >= 7'd16)
                            for (int k = 0; k < 16; k++) w[k] <= ext[k+UNROLL];
                        if (cnt == 6'(NCYC - 1)) begin
                            cnt   <= '0;
                            state <= S_FINAL;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    S_FINAL: begin
                        for (int n = 0; n < 8; n++)
                            h_reg[255-32*n -: 32] <= h_reg[255-32*n -: 32] + work[255-32*n -: 32];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sha256_core_param.sv
// Directed bench for sha256_core_param: three unroll factors side by side, known-answer digests.
module tb_sha256_core_param;
    localparam logic [255:0] IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_NONCE_INJECT_EN
    localparam int NCAP = 15;
    logic [31:0] nonce;
`else
    localparam int NCAP = 16;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, cont, abort;
    logic [255:0]  state_in;
    logic [255:0]  so1, so4, so16;
    logic          bz1, bz4, bz16, dn1, dn4, dn16;
    logic [31:0]   blk [0:15];
    logic          rnd_en = 1'b0;
    logic          rnd_bit = 1'b1;
    logic          rdy_v;

    sha256_core_param_if b1 ();
    sha256_core_param_if b4 ();
    sha256_core_param_if b16 ();

    assign rdy_v    = rnd_en ? rnd_bit : 1'b1;
    assign b1.rdy   = rdy_v;
    assign b4.rdy   = rdy_v;
    assign b16.rdy  = rdy_v;
    assign b1.data  = blk[b1.addr];
    assign b4.data  = blk[b4.addr];
    assign b16.data = blk[b16.addr];

    sha256_core_param #(.UNROLL(1), .NONCE_WORD(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
`ifdef SHA256_NONCE_INJECT_EN
        .nonce(nonce),
`endif
        .state_in(state_in), .state_out(so1), .busy(bz1), .done(dn1), .bus(b1));
    sha256_core_param #(.UNROLL(4), .NONCE_WORD(3)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
`ifdef SHA256_NONCE_INJECT_EN
        .nonce(nonce),
`endif
        .state_in(state_in), .state_out(so4), .busy(bz4), .done(dn4), .bus(b4));
    sha256_core_param #(.UNROLL(16), .NONCE_WORD(3)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
`ifdef SHA256_NONCE_INJECT_EN
        .nonce(nonce),
`endif
        .state_in(state_in), .state_out(so16), .busy(bz16), .done(dn16), .bus(b16));

    // Bus-side monitors for the UNROLL=4 core: capture count and address stability under stall.
    int         cap4 = 0;
    int         addr_bad = 0;
    logic       stall_q = 1'b0;
    logic [3:0] stall_addr = '0;
    always @(posedge clk) begin
        if (b4.rq && rdy_v) cap4 <= cap4 + 1;
        stall_q    <= b4.rq && !rdy_v;
        stall_addr <= b4.addr;
    end
    always @(negedge clk) begin
        rnd_bit <= ($urandom_range(0, 99) < 30);
        if (stall_q && b4.addr !== stall_addr) addr_bad <= addr_bad + 1;
    end

    int checks = 0;
    int errors = 0;
    int lat1, lat4, lat16, nd1, nd4, nd16;
    logic ab_busy_pre, ab_rq_pre, ab_busy_post, ab_rq_post;
    int c0, a0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_msg(input int which);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        case (which)
            0: begin blk[0] = 32'h61626380; blk[15] = 32'h00000018; end
            1: begin
                for (int i = 0; i < 14; i++) blk[i] = 32'h61626364 + 32'h01010101 * i;
                blk[14] = 32'h80000000;
            end
            default: blk[15] = 32'h000001c0;
        endcase
`ifdef SHA256_NONCE_INJECT_EN
        nonce  = blk[3];
        blk[3] = 32'hffffffff;
`endif
    endtask

    // The edge that samples start counts as cycle 1; n is the cycle whose edge just passed.
    task automatic go(input logic c, input logic [255:0] si, input int budget, input int poke, input int abt);
        lat1 = 0; lat4 = 0; lat16 = 0; nd1 = 0; nd4 = 0; nd16 = 0;
        @(negedge clk);
        cont = c; state_in = si; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n == poke) begin start = 1'b1; state_in = '1; end
            if (n == poke + 1) begin start = 1'b0; state_in = si; end
            if (n == abt) begin ab_busy_pre = bz4; ab_rq_pre = b4.rq; abort = 1'b1; end
            if (n == abt + 1) begin ab_busy_post = bz4; ab_rq_post = b4.rq; abort = 1'b0; end
            if (dn1)  begin nd1++;  if (lat1 == 0)  lat1 = n;  end
            if (dn4)  begin nd4++;  if (lat4 == 0)  lat4 = n;  end
            if (dn16) begin nd16++; if (lat16 == 0) lat16 = n; end
            @(posedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; state_in = '0;
        load_msg(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rq", {b1.rq, b4.rq, b16.rq}, 0);
        check("rst_busy", {bz1, bz4, bz16}, 0);
        check("rst_done", {dn1, dn4, dn16}, 0);
        check("rst_addr", b4.addr, 0);
        check("rst_state_out", so4, 0);
        rst_n = 1'b1;

        // "abc" on all three unroll factors
        c0 = cap4;
        go(1'b0, IV, 100, -10, -10);
        check("abc_lat_u1", lat1, 82);
        check("abc_lat_u4", lat4, 34);
        check("abc_lat_u16", lat16, 22);
        check("abc_pulses_u1", nd1, 1);
        check("abc_pulses_u4", nd4, 1);
        check("abc_pulses_u16", nd16, 1);
        check("abc_dig_u1", so1, ABC);
        check("abc_dig_u4", so4, ABC);
        check("abc_dig_u16", so16, ABC);
        check("abc_captures", cap4 - c0, NCAP);

        // two-block message, second block chained from H
        load_msg(1);
        go(1'b0, IV, 40, -10, -10);
        load_msg(2);
        go(1'b1, '0, 40, -10, -10);
        check("two_blk_dig", so4, TWO);
        check("two_blk_lat", lat4, 34);

        // "abc" with a sparse random rdy
        load_msg(0);
        rnd_en = 1'b1;
        c0 = cap4; a0 = addr_bad;
        go(1'b0, IV, 400, -10, -10);
        rnd_en = 1'b0;
        check("rnd_dig", so4, ABC);
        check("rnd_pulses", nd4, 1);
        check("rnd_captures", cap4 - c0, NCAP);
        check("rnd_addr_hold", addr_bad - a0, 0);

        // abort sampled at the end of the third COMPUTE cycle
        go(1'b0, IV, 40, -10, 19);
        check("abort_busy_pre", ab_busy_pre, 1);
        check("abort_rq_pre", ab_rq_pre, 0);
        check("abort_busy_post", ab_busy_post, 0);
        check("abort_rq_post", ab_rq_post, 0);
        check("abort_no_done", nd4, 0);
        check("abort_h_kept", so4, IV);

        go(1'b0, IV, 40, -10, -10);
        check("fresh_dig", so4, ABC);
        check("fresh_lat", lat4, 34);

        // start with junk state_in while busy must be ignored
        go(1'b0, IV, 40, 8, -10);
        check("busy_start_dig", so4, ABC);
        check("busy_start_lat", lat4, 34);
        check("busy_start_pulses", nd4, 1);

        // asynchronous reset in the middle of LOAD
        @(negedge clk);
        cont = 1'b0; state_in = IV; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_rq", b4.rq, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rq", b4.rq, 0);
        check("midrst_busy", bz4, 0);
        check("midrst_state_out", so4, 0);
        check("midrst_addr", b4.addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {bz4, b4.rq, dn4}, 0);

        go(1'b0, IV, 40, -10, -10);
        check("recover_dig", so4, ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
